dbf_coarse_delay: RTL and testbench

//  Per-channel steering delay front end of the DBF datapath; drives the fine-delay interpolator.

---
 rtl/dbf_pkg.sv | 37 +++
 rtl/dbf_coef_rom.sv | 39 +++
 rtl/dbf_coarse_delay.sv | 150 +++++++++++++++
 tb/tb_dbf_coarse_delay.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbf_pkg
// Description : Shared definitions for the DBF coarse-delay front end.
//               Holds the default width localparams, the UNITY coefficient
//               constant, the delay-controller state encoding and the MMSE
//               fractional-delay coefficient table.
// Revision    : 1.0 - initial release
// ============================================================================
package dbf_pkg;

  localparam int DBF_INPUT_WD    = 12;
  localparam int DBF_FILTER_COFF = 16;
  localparam int DBF_MAX_DELAY   = 64;
  localparam int DBF_FRAC_WD     = 4;

  // Q1.(FILTER_COFF-2) representation of 1.0
  localparam logic [DBF_FILTER_COFF-1:0] DBF_UNITY = 16'd16384;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } dbf_state_e;

  // MMSE-optimised h1 for each fractional step; h0 is UNITY - h1.
  // Entry 0 is exactly zero so frac=0 gives the pure {UNITY, 0} pair.
  localparam logic [DBF_FILTER_COFF-1:0] DBF_MMSE_H1 [2**DBF_FRAC_WD] = '{
    16'd0,     16'd1000,  16'd2030,  16'd3080,
    16'd4140,  16'd5200,  16'd6270,  16'd7330,
    16'd8192,  16'd9054,  16'd10114, 16'd11174,
    16'd12244, 16'd13304, 16'd14354, 16'd15384
  };

endpackage : dbf_pkg
`default_nettype wire

// File: rtl/dbf_coef_rom.sv
`default_nettype none
// ============================================================================
// Module      : dbf_coef_rom
// Description : Fractional delay -> 2-tap interpolator coefficients {h0,h1}.
//               Purely combinational; the caller registers the result.
//               Build option DBF_MMSE_LUT_EN selects the MMSE table in
//               dbf_pkg; otherwise the coefficients are linear:
//                 h1 = frac * UNITY >> FRAC_WD,  h0 = UNITY - h1
// Ports       : frac  in   FRAC_WD      fractional delay
//               h0    out  FILTER_COFF  current-sample tap
//               h1    out  FILTER_COFF  previous-sample tap
// Revision    : 1.0 - initial release
// ============================================================================
module dbf_coef_rom #(
  parameter int FILTER_COFF = 16,
  parameter int FRAC_WD     = 4
) (
  input  logic [FRAC_WD-1:0]     frac,
  output logic [FILTER_COFF-1:0] h0,
  output logic [FILTER_COFF-1:0] h1
);
  import dbf_pkg::*;

  localparam logic [FILTER_COFF-1:0] UNITY =
    {{(FILTER_COFF-1){1'b0}}, 1'b1} << (FILTER_COFF-2);

  always_comb begin
`ifdef DBF_MMSE_LUT_EN
    h1 = FILTER_COFF'(DBF_MMSE_H1[frac]);
`else
    // UNITY is a power of two, so the multiply-and-shift reduces to
    // placing frac just below the binary point.
    h1 = {{(FILTER_COFF-FRAC_WD){1'b0}}, frac} << (FILTER_COFF-2-FRAC_WD);
`endif
    h0 = UNITY - h1;
  end

endmodule : dbf_coef_rom
`default_nettype wire

// File: rtl/dbf_coarse_delay.sv
`default_nettype none
// ============================================================================
// Module      : dbf_coarse_delay
// Description : Per-channel steering delay front end of the DBF datapath.
//               Integer sample delay through a circular buffer, fractional
//               delay converted to fine-stage coefficients h0/h1, and a
//               load/busy handshake that inserts a flush bubble on reload.
//               Build option DBF_MMSE_LUT_EN (in dbf_coef_rom) selects MMSE
//               coefficients instead of linear ones.
// Ports       : clk         in   1            rising-edge clock
//               reset_n     in   1            async active-low reset
//               din         in   INPUT_WD     signed ADC sample
//               din_valid   in   1            din qualifier
//               delay_int   in   AW           coarse delay, samples
//               delay_frac  in   FRAC_WD      fractional delay
//               delay_load  in   1            load request
//               delay_busy  out  1            load in progress
//               dout        out  INPUT_WD     delayed sample
//               dout_valid  out  1            dout qualifier
//               h0, h1      out  FILTER_COFF  fine-stage coefficients
// Revision    : 1.0 - initial release
// ============================================================================
module dbf_coarse_delay import dbf_pkg::*; #(
  parameter int INPUT_WD    = DBF_INPUT_WD,
  parameter int FILTER_COFF = DBF_FILTER_COFF,
  parameter int MAX_DELAY   = DBF_MAX_DELAY,
  parameter int FRAC_WD     = DBF_FRAC_WD,
  localparam int AW         = $clog2(MAX_DELAY)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INPUT_WD-1:0]    din,
  input  logic                   din_valid,
  input  logic [AW-1:0]          delay_int,
  input  logic [FRAC_WD-1:0]     delay_frac,
  input  logic                   delay_load,
  output logic                   delay_busy,
  output logic [INPUT_WD-1:0]    dout,
  output logic                   dout_valid,
  output logic [FILTER_COFF-1:0] h0,
  output logic [FILTER_COFF-1:0] h1
);

  dbf_state_e             state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]          d_int_q, d_int_d;
  logic [FRAC_WD-1:0]     frac_q, frac_d;
  logic [INPUT_WD-1:0]    dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic [FILTER_COFF-1:0] h0_q, h0_d, h1_q, h1_d;

  logic [INPUT_WD-1:0]    mem_q [MAX_DELAY];
  logic [AW-1:0]          rd_addr;
  logic [INPUT_WD-1:0]    rd_data;
  logic [FILTER_COFF-1:0] rom_h0, rom_h1;
  logic                   load_acc;
  logic                   filled;

  dbf_coef_rom #(
    .FILTER_COFF (FILTER_COFF),
    .FRAC_WD     (FRAC_WD)
  ) u_coef_rom (
    .frac (frac_q),
    .h0   (rom_h0),
    .h1   (rom_h1)
  );

  // Distributed RAM: one write port, one asynchronous read port.
  always_ff @(posedge clk) begin
    if (din_valid) mem_q[wr_ptr_q] <= din;
  end

  // Modulo-MAX_DELAY subtraction; the read sees the pre-write contents, so
  // this is the sample written d_int samples before the current one.
  assign rd_addr    = wr_ptr_q - d_int_q;
  assign rd_data    = mem_q[rd_addr];
  assign filled     = (fill_cnt_q >= d_int_q);
  assign delay_busy = (state_q == ST_FLUSH) || (state_q == ST_FILL);
  assign load_acc   = delay_load && !delay_busy;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    d_int_d    = d_int_q;
    frac_d     = frac_q;
    dout_d     = dout_q;
    h0_d       = h0_q;
    h1_d       = h1_q;

    if (din_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_cnt_q != {AW{1'b1}}) fill_cnt_d = fill_cnt_q + 1'b1;
      dout_d = (d_int_q == '0) ? din : rd_data;
    end

    if (load_acc) begin
      d_int_d = delay_int;
      frac_d  = delay_frac;
    end

    case (state_q)
      ST_IDLE:  if (load_acc) state_d = ST_FLUSH;
      ST_FLUSH: begin
        h0_d    = rom_h0;
        h1_d    = rom_h1;
        state_d = filled ? ST_RUN : ST_FILL;
      end
      ST_FILL:  if (filled) state_d = ST_RUN;
      ST_RUN:   if (load_acc) state_d = ST_FLUSH;
      default:  state_d = ST_IDLE;
    endcase

    // A sample is good once the buffer holds enough history for it; the
    // sample presented on the load cycle falls into the bubble.
    dout_valid_d = din_valid && (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      d_int_q      <= '0;
      frac_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      h0_q         <= '0;
      h1_q         <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      d_int_q      <= d_int_d;
      frac_q       <= frac_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      h0_q         <= h0_d;
      h1_q         <= h1_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign h0         = h0_q;
  assign h1         = h1_q;

endmodule : dbf_coarse_delay
`default_nettype wire

// File: tb/tb_dbf_coarse_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbf_coarse_delay
// Description : Self-checking bench for dbf_coarse_delay (linear build).
//               Input samples are 1,2,3,... in arrival order and are kept in
//               a history array; every valid output is compared against the
//               sample that lies the active delay behind its source sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbf_coarse_delay;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic [5:0]  delay_int = '0;
  logic [3:0]  delay_frac = '0;
  logic        delay_load = 1'b0;
  logic        delay_busy;
  logic [11:0] dout;
  logic        dout_valid;
  logic [15:0] h0, h1;

  always #5 clk = ~clk;

  dbf_coarse_delay dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .delay_int  (delay_int),
    .delay_frac (delay_frac),
    .delay_load (delay_load),
    .delay_busy (delay_busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .h0         (h0),
    .h1         (h1)
  );

  typedef struct {
    logic [5:0]  d;
    logic [3:0]  f;
    logic [15:0] h0;
    logic [15:0] h1;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] hist [0:8191];
  int          n_wr = 0;
  int          exp_d = 0;
  int          n_vout = 0;
  bit          mirror_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then inspect outputs 1 unit later.
  task automatic tick(input logic v);
    int idx;
    idx = -1;
    din_valid = v;
    din = 12'(n_wr + 1);
    @(posedge clk);
    if (v) begin
      hist[n_wr] = din;
      idx = n_wr;
      n_wr++;
    end
    #1;
    if (mirror_chk) check("valid_mirror", 32'(dout_valid), 32'(v));
    if (dout_valid === 1'b1) begin
      n_vout++;
      if (idx < exp_d) check("valid_has_source", 32'(idx >= exp_d), 32'd1);
      else check("dout_lag", 32'(dout), 32'(hist[idx - exp_d]));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_h0"}, 32'(h0), 32'd0);
    check({tag, "_h1"}, 32'(h1), 32'd0);
    check({tag, "_busy"}, 32'(delay_busy), 32'd0);
  endtask

  task automatic do_reset();
    delay_load = 1'b0;
    din_valid  = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Issue a load, then clock continuous samples while busy is observed.
  // With hold set, delay_load stays high throughout busy and delay_int is
  // changed, so a second acceptance would show up as a wrong lag.
  task automatic do_load(input logic [5:0] d, input logic [3:0] f, input logic v,
                         input bit hold, output int busy_n, output logic first_valid);
    delay_load = 1'b1;
    delay_int  = d;
    delay_frac = f;
    exp_d      = int'(d);
    tick(v);
    if (!hold) delay_load = 1'b0;
    busy_n = 0;
    while (delay_busy === 1'b1 && busy_n < 200) begin
      busy_n++;
      if (hold) delay_int = d + 6'd4;
      tick(1'b1);
    end
    delay_load  = 1'b0;
    first_valid = dout_valid;
    check("busy_bounded", 32'(busy_n < 200), 32'd1);
  endtask

  initial begin
    vec_t vecs [7];
    int   bn;
    logic fv;
    int   base;

    vecs[0] = '{6'd0,  4'd8,  16'd8192,  16'd8192};
    vecs[1] = '{6'd0,  4'd0,  16'd16384, 16'd0};
    vecs[2] = '{6'd1,  4'd1,  16'd15360, 16'd1024};
    vecs[3] = '{6'd7,  4'd15, 16'd1024,  16'd15360};
    vecs[4] = '{6'd63, 4'd4,  16'd12288, 16'd4096};
    vecs[5] = '{6'd32, 4'd12, 16'd4096,  16'd12288};
    vecs[6] = '{6'd2,  4'd3,  16'd13312, 16'd3072};

    // Reset values
    do_reset();

    // Load int=3 frac=0 from IDLE; samples start on the FLUSH cycle
    do_load(6'd3, 4'd0, 1'b0, 1'b0, bn, fv);
    check("t1_busy_cycles", 32'(bn), 32'd4);
    check("t1_first_valid", 32'(fv), 32'd1);
    check("t1_first_dout", 32'(dout), 32'd1);
    check("t1_h0", 32'(h0), 32'd16384);
    check("t1_h1", 32'(h1), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b1);

    // RUN at int=2 with a short history, then reload int=5
    do_reset();
    base = n_wr;
    do_load(6'd2, 4'd0, 1'b0, 1'b0, bn, fv);
    check("t3_busy_int2", 32'(bn), 32'd3);
    check("t3_first_dout", 32'(dout), 32'(hist[base]));
    do_load(6'd5, 4'd0, 1'b1, 1'b0, bn, fv);
    check("t3_busy_int5", 32'(bn), 32'd2);
    check("t3_resume_valid", 32'(fv), 32'd1);
    for (int i = 0; i < 70; i++) tick(1'b1);

    // Coefficient table with a saturated fill counter: one bubble each
    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].d, vecs[i].f, 1'b1, 1'b0, bn, fv);
      check($sformatf("vec%0d_busy", i), 32'(bn), 32'd1);
      check($sformatf("vec%0d_valid", i), 32'(fv), 32'd1);
      check($sformatf("vec%0d_h0", i), 32'(h0), 32'(vecs[i].h0));
      check($sformatf("vec%0d_h1", i), 32'(h1), 32'(vecs[i].h1));
      for (int k = 0; k < 8; k++) tick(1'b1);
    end

    // Gapped input, one valid sample in three, int=4
    do_load(6'd4, 4'd0, 1'b1, 1'b0, bn, fv);
    check("t4_busy", 32'(bn), 32'd1);
    n_vout = 0;
    mirror_chk = 1'b1;
    for (int i = 0; i < 30; i++) tick(i % 3 == 0);
    mirror_chk = 1'b0;
    check("t4_valid_count", 32'(n_vout), 32'd10);

    // delay_load held high through busy: only one load may be taken
    do_reset();
    do_load(6'd2, 4'd0, 1'b0, 1'b1, bn, fv);
    check("t5_busy_hold", 32'(bn), 32'd3);
    check("t5_first_valid", 32'(fv), 32'd1);
    for (int i = 0; i < 6; i++) tick(1'b1);
    check("t5_busy_after", 32'(delay_busy), 32'd0);

    // Reset pulse in the middle of FILL
    delay_load = 1'b1;
    delay_int  = 6'd20;
    delay_frac = 4'd5;
    exp_d      = 20;
    tick(1'b1);
    delay_load = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1);
    check("t5_in_fill_busy", 32'(delay_busy), 32'd1);
    check("t5_in_fill_h1", 32'(h1), 32'd5120);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("t5_midfill");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0);
    check("t5_idle_busy", 32'(delay_busy), 32'd0);
    check("t5_idle_valid", 32'(dout_valid), 32'd0);
    do_load(6'd2, 4'd0, 1'b0, 1'b0, bn, fv);
    check("t5_reload_busy", 32'(bn), 32'd3);

    // Maximum delay with wrap-around; fill count is 4 on entry to FLUSH
    do_load(6'd63, 4'd0, 1'b1, 1'b0, bn, fv);
    check("t6_busy", 32'(bn), 32'd60);
    check("t6_first_valid", 32'(fv), 32'd1);
    n_vout = 0;
    mirror_chk = 1'b1;
    for (int i = 0; i < 210; i++) tick(1'b1);
    mirror_chk = 1'b0;
    check("t6_valid_count", 32'(n_vout), 32'd210);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dbf_coarse_delay
`default_nettype wire
